// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the LUT configuration loader: FSM state encoding
// and the default word width / sync pattern.
package fpga_cfg_pkg;

  localparam int          CFG_W_DEF     = 16;
  localparam logic [15:0] SYNC_WORD_DEF = 16'hB00B;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    LOAD  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage : fpga_cfg_pkg

// File: rtl/fpga_cfg_loader_if.sv
// Serial bitstream handshake plus the broadcast config bus that feeds the
// fpga_4lut array. The loader owns the slave side; the bitstream source and
// the LUT array together form the master side.
interface fpga_cfg_loader_if #(
  parameter int NUM_LUTS = 4,
  parameter int CFG_W    = 16
) ();

  logic                bit_i;
  logic                bit_valid_i;
  logic                bit_ready_o;
  logic [CFG_W-1:0]    config_o;
  logic [NUM_LUTS-1:0] config_we_o;

  modport master (
    output bit_i,
    output bit_valid_i,
    input  bit_ready_o,
    input  config_o,
    input  config_we_o
  );

  modport slave (
    input  bit_i,
    input  bit_valid_i,
    output bit_ready_o,
    output config_o,
    output config_we_o
  );

endinterface : fpga_cfg_loader_if

// File: rtl/fpga_cfg_shreg.sv
// Shift window and bit counter. Only the last CFG_W-1 bits are stored; the
// window output appends the bit being offered this cycle, so it already shows
// the post-shift value that sync matching and word capture need.
module fpga_cfg_shreg
  import fpga_cfg_pkg::*;
#(
  parameter int CFG_W = CFG_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             shift_en_i,
  input  logic             clear_i,
  input  logic             bit_i,
  output logic [CFG_W-1:0] window_o,
  output logic             word_complete_o
);

  localparam int CNT_W = $clog2(CFG_W);

  logic [CFG_W-2:0] hist_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_last;

  assign cnt_last        = (cnt_q == CNT_W'(CFG_W - 1));
  assign window_o        = {hist_q, bit_i};
  assign word_complete_o = shift_en_i && cnt_last;

  // Shift history and bit counter; clear wins over a simultaneous shift.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      hist_q <= '0;
      cnt_q  <= '0;
    end else if (shift_en_i) begin
      hist_q <= window_o[CFG_W-2:0];
      cnt_q  <= cnt_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule : fpga_cfg_shreg

// File: rtl/fpga_cfg_loader.sv
// Configuration loader: hunts for the sync word in a serial bitstream, then
// assembles NUM_LUTS words MSB first and strobes each into its LUT through a
// shared config bus and a one-hot write enable.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int               NUM_LUTS  = 4,
  parameter int               CFG_W     = CFG_W_DEF,
  parameter logic [CFG_W-1:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  fpga_cfg_loader_if.slave   bus,
  output logic               busy_o,
  output logic               done_o
);

  localparam int IDX_W = $clog2(NUM_LUTS);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] lut_idx_q;
  logic [CFG_W-1:0] config_q;
  logic [CFG_W-1:0] window;
  logic             word_complete;
  logic             bit_ready;
  logic             transfer;
  logic             start_accept;
  logic             shreg_clear;
  logic             last_lut;

  assign bit_ready = (state_q == SYNC) || (state_q == LOAD);
  assign transfer  = bus.bit_valid_i && bit_ready;
  assign last_lut  = (lut_idx_q == IDX_W'(NUM_LUTS - 1));

  fpga_cfg_shreg #(
    .CFG_W (CFG_W)
  ) u_shreg (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .shift_en_i      (transfer),
    .clear_i         (shreg_clear),
    .bit_i           (bus.bit_i),
    .window_o        (window),
    .word_complete_o (word_complete)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic plus the clear/start qualifiers it implies.
  // NOTE: every combinational output gets a default first so no path through
  // the case leaves a value unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    start_accept = 1'b0;
    shreg_clear  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d      = SYNC;
          start_accept = 1'b1;
          shreg_clear  = 1'b1;
        end
      end
      SYNC: begin
        if (transfer && (window == SYNC_WORD)) begin
          state_d     = LOAD;
          shreg_clear = 1'b1;
        end
      end
      LOAD: begin
        if (word_complete) state_d = WRITE;
      end
      WRITE: begin
        state_d = last_lut ? DONE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Config holding register and LUT index. config_q only moves when a word
  // completes, so it stays stable through WRITE and the following LOAD.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      config_q  <= '0;
      lut_idx_q <= '0;
    end else begin
      if (state_q == LOAD && word_complete) config_q <= window;
      if (start_accept) begin
        lut_idx_q <= '0;
      end else if (state_q == WRITE && !last_lut) begin
        lut_idx_q <= lut_idx_q + IDX_W'(1);
      end
    end
  end

  // Outputs decoded from state so an async reset clears them immediately.
  always_comb begin
    bus.bit_ready_o = bit_ready;
    bus.config_o    = config_q;
    bus.config_we_o = (state_q == WRITE) ? (NUM_LUTS'(1) << lut_idx_q) : '0;
    busy_o          = (state_q == SYNC) || (state_q == LOAD) || (state_q == WRITE);
    done_o          = (state_q == DONE);
  end

endmodule : fpga_cfg_loader

// File: tb/tb_fpga_cfg_loader.sv
// Scoreboard bench for fpga_cfg_loader: stimulus pushes expected LUT writes,
// a negedge monitor pops and compares whenever a write strobe appears.
module tb_fpga_cfg_loader;
  import fpga_cfg_pkg::*;

  localparam int          NUM_LUTS = 4;
  localparam int          CFG_W    = 16;
  localparam logic [15:0] SYNC     = 16'hB00B;

  typedef struct packed {
    logic [NUM_LUTS-1:0] we;
    logic [CFG_W-1:0]    cfg;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;

  fpga_cfg_loader_if #(.NUM_LUTS(NUM_LUTS), .CFG_W(CFG_W)) bus ();

  fpga_cfg_loader #(
    .NUM_LUTS  (NUM_LUTS),
    .CFG_W     (CFG_W),
    .SYNC_WORD (SYNC)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .bus     (bus),
    .busy_o  (busy),
    .done_o  (done)
  );

  always #5 clk = ~clk;

  wr_t              sb[$];
  int               compared   = 0;
  int               mismatched = 0;
  logic [CFG_W-1:0] prev_cfg   = '0;
  logic [CFG_W-1:0] lut0_cfg   = '0;
  logic [3:0]       lut_sel    = 4'h4;
  bit               last_seen  = 1'b0;
  wr_t              exp_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every write strobe against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_seen = 1'b0;
      end else begin
        check("busy_done_exclusive", {31'd0, busy && done}, 0);
        if (last_seen) check("done_after_last_write", {30'd0, busy, done}, 2'b01);
        last_seen = bus.config_we_o[NUM_LUTS-1];
        if (bus.config_we_o != '0) begin
          check("ready_low_in_write", {31'd0, bus.bit_ready_o}, 0);
          if (sb.size() == 0) begin
            check("unexpected_write", {28'd0, bus.config_we_o}, 0);
          end else begin
            exp_wr = sb.pop_front();
            check("write_we", {28'd0, bus.config_we_o}, {28'd0, exp_wr.we});
            check("write_cfg", {16'd0, bus.config_o}, {16'd0, exp_wr.cfg});
          end
          if (bus.config_we_o[0]) lut0_cfg = bus.config_o;
        end else begin
          check("cfg_hold", {16'd0, bus.config_o}, {16'd0, prev_cfg});
        end
      end
      prev_cfg = bus.config_o;
    end
  end

  // Expected writes for four words packed MSB-first into ws.
  task automatic push_words(input logic [63:0] ws);
    for (int k = 0; k < NUM_LUTS; k++) begin
      sb.push_back('{we: NUM_LUTS'(1) << k, cfg: ws[63-16*k -: 16]});
    end
  endtask

  // Offer n bits of w MSB first, holding each until it is accepted.
  task automatic send_bits(input logic [15:0] w, input int n, input bit gaps);
    logic rdy;
    int   tries;
    for (int i = n - 1; i >= 0; i--) begin
      tries = 0;
      do begin
        @(negedge clk);
        bus.bit_i       = w[i];
        bus.bit_valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        rdy             = bus.bit_ready_o;
        @(posedge clk);
        tries++;
      end while (!(bus.bit_valid_i && rdy) && tries < 100);
      if (tries >= 100) begin
        check("bit_accept_timeout", 0, 1);
        return;
      end
    end
  endtask

  task automatic stream(input logic [63:0] ws, input bit gaps);
    send_bits(SYNC, 16, gaps);
    for (int k = 0; k < NUM_LUTS; k++) send_bits(ws[63-16*k -: 16], 16, gaps);
    @(negedge clk);
    bus.bit_valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ready_after_start", {31'd0, bus.bit_ready_o}, 1);
    check("busy_after_start", {30'd0, busy, done}, 2'b10);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && !done; i++) @(negedge clk);
    check("done_reached", {31'd0, done}, 1);
    check("scoreboard_drained", sb.size(), 0);
  endtask

  localparam logic [63:0] NOMINAL = 64'hF0F0_ABCD_1234_5678;

  initial begin
    bus.bit_i       = 1'b0;
    bus.bit_valid_i = 1'b0;

    // Reset held with random inputs: every output stays 0.
    repeat (5) begin
      @(negedge clk);
      start           = 1'($urandom_range(0, 1));
      bus.bit_i       = 1'($urandom_range(0, 1));
      bus.bit_valid_i = 1'($urandom_range(0, 1));
      #1;
      check("rst_outputs", {bus.config_o, 12'd0, bus.config_we_o},  0);
      check("rst_flags", {29'd0, bus.bit_ready_o, busy, done}, 0);
    end
    @(negedge clk);
    start = 1'b0;
    bus.bit_valid_i = 1'b0;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle_no_ready", {29'd0, bus.bit_ready_o, busy, done}, 0);
    end

    // Nominal load, then the LUT 0 lookup at {i0,i1,i2,i3}=4'h4.
    push_words(NOMINAL);
    pulse_start();
    stream(NOMINAL, 1'b0);
    wait_done();
    check("lut0_out", {31'd0, lut0_cfg[lut_sel]}, 1);

    // Leading garbage 3'b101 before the sync word; start issued from DONE.
    push_words(NOMINAL);
    pulse_start();
    send_bits(16'h0005, 3, 1'b0);
    stream(NOMINAL, 1'b0);
    wait_done();

    // Random valid gaps.
    push_words(NOMINAL);
    pulse_start();
    stream(NOMINAL, 1'b1);
    wait_done();

    // start pulses during SYNC and LOAD are ignored.
    push_words(NOMINAL);
    pulse_start();
    fork
      stream(NOMINAL, 1'b0);
      begin
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    wait_done();

    // Reset in the middle of the second word, then a fresh load.
    sb.push_back('{we: 4'b0001, cfg: 16'hF0F0});
    pulse_start();
    send_bits(SYNC, 16, 1'b0);
    send_bits(16'hF0F0, 16, 1'b0);
    send_bits(16'h00AB, 8, 1'b0);
    @(negedge clk);
    bus.bit_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midload_rst_bus", {bus.config_o, 12'd0, bus.config_we_o}, 0);
    check("midload_rst_flags", {29'd0, bus.bit_ready_o, busy, done}, 0);
    check("midload_sb_drained", sb.size(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_words(64'h1111_2222_3333_4444);
    pulse_start();
    stream(64'h1111_2222_3333_4444, 1'b0);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_fpga_cfg_loader

// File: doc/fpga_cfg_loader.md
# fpga_cfg_loader

Configuration loader for the FPGA fabric's 4-input LUTs. It accepts a serial bitstream over a valid/ready handshake and locks onto a sync word. It then assembles NUM_LUTS words of CFG_W bits, MSB first, and writes each word into its fpga_4lut through the shared config bus and a one-hot write-enable. It sits directly upstream of the fpga_4lut array, driving each instance's config_i / config_we_i pins.

## Interface
- NUM_LUTS, 4: number of LUTs in the chain; must be ≥ 2.
- CFG_W, 16: LUT configuration word width.
- SYNC_WORD, 16'hB00B: CFG_W-bit pattern that precedes the payload.

- clk_i  in  1  clock; all state is updated on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle request to begin a load.
- bit_i  in  1  serial bitstream data.
- bit_valid_i  in  1  bit_i is valid this cycle.
- bit_ready_o  out  1  loader accepts a bit this cycle.
- config_o  out  CFG_W  word broadcast to every fpga_4lut config_i.
- config_we_o  out  NUM_LUTS  one-hot write strobe; bit k drives LUT k config_we_i.
- busy_o  out  1  high in SYNC, LOAD and WRITE.
- done_o  out  1  all LUTs written; held until the next accepted start.

## Operation
- A bit is transferred on a clock edge where bit_valid_i && bit_ready_o.
- States:
  - IDLE: waiting for start.
  - SYNC: hunting for the sync word.
  - LOAD: shifting in a configuration word.
  - WRITE: strobing the word into one LUT.
  - DONE: load complete.
- IDLE or DONE, start_i=1 → SYNC. On that transition: clear done_o, the shift window, the bit counter and the LUT index.
- SYNC:
  - bit_ready_o=1.
  - Each transferred bit is shifted into a CFG_W window: window = {window[CFG_W-2:0], bit_i}.
  - When the post-shift window equals SYNC_WORD → LOAD.
  - Window matching is sliding; any number of leading garbage bits is tolerated.
- LOAD:
  - bit_ready_o=1; bits are shifted in MSB first.
  - The bit counter counts 0..CFG_W-1.
  - On the CFG_W-th transferred bit: latch the completed word into the config_o holding register, then → WRITE.
- WRITE:
  - Lasts exactly one cycle; bit_ready_o=0.
  - config_we_o = 1 << lut_idx.
  - Then: if lut_idx == NUM_LUTS-1 → DONE; otherwise lut_idx++ and bit counter = 0 → LOAD.
- DONE: done_o=1, bit_ready_o=0.
- start_i is ignored in SYNC, LOAD and WRITE.
- Bits are not consumed in IDLE, WRITE or DONE (bit_ready_o=0).
- config_o changes only when a word completes. It holds its value through the WRITE cycle and through the whole next LOAD phase.
- Counter widths: bit counter $clog2(CFG_W); LUT index $clog2(NUM_LUTS). Neither wraps within one load.

## Timing
- Reset values:
  - state = IDLE.
  - config_o = 0, config_we_o = 0.
  - bit_ready_o = 0, busy_o = 0, done_o = 0.
- start_i sampled at edge t → bit_ready_o=1 from cycle t+1.
- Last bit of a word transferred at edge t → config_o updated and config_we_o asserted during cycle t+1, for exactly one cycle.
- Peak throughput is one word per CFG_W+1 cycles.
- Last WRITE cycle ends at edge t → done_o=1 and busy_o=0 from cycle t+1.
- busy_o and done_o are never high together.
- Gaps in bit_valid_i stall the shift and the counters without penalty; there is no timeout.
- rst_ni asserted mid-load: every output clears immediately, asynchronously. The partial word is discarded. After a new start, loading begins again at LUT 0.

## Structure
- Package fpga_cfg_pkg holds:
  - the state enum (IDLE, SYNC, LOAD, WRITE, DONE);
  - localparams CFG_W_DEF = 16 and SYNC_WORD_DEF = 16'hB00B.
- Sub-module fpga_cfg_shreg contains the CFG_W shift window and bit counter.
  - Inputs: shift enable, clear.
  - Outputs: window and word_complete.
  - The FSM and the LUT index stay in the top level.

## Test plan
- Reset: hold rst_ni=0 with random inputs → all outputs 0. Release reset with no start → state stays IDLE and bit_ready_o stays 0.
- Nominal load: pulse start, then stream SYNC_WORD followed by F0F0, ABCD, 1234, 5678 continuously. Required response:
  - config_we_o pulses 0001, 0010, 0100, 1000, each lasting one cycle, with config_o matching each word;
  - done_o rises the cycle after the last pulse.
  - With a real fpga_4lut on bit 0, inputs {i0,i1,i2,i3}=4'h4 → lut_o=1.
- Leading garbage: send 3'b101 before SYNC_WORD → word alignment and written values are identical to the nominal load.
- Backpressure and gaps: deassert bit_valid_i randomly → same writes. bit_ready_o=0 in every WRITE cycle, and no bit is lost or duplicated.
- Reset mid-LOAD, during the second word: outputs go to 0 immediately. A new start plus stream 1111, 2222, 3333, 4444 → the first write goes to LUT 0 with value 1111.
- start_i pulsed during SYNC and LOAD → no effect; the result matches the nominal load. A start in DONE clears done_o and begins a new load.
